preadder_seq: RTL and testbench

- Multi-cycle sequencer for the FP32 add/sub pre-adder stage.
- Accepts one operand pair per transaction over a valid/ready handshake.
- Unpacks and extends both mantissas, then aligns the smaller-exponent mantissa with an iterative shifter of SHIFT_STEP bits/cycle.
- Compares magnitudes, swaps, resolves the result sign, and presents {sign, exp, mantis_great, mantis_small} to the downstream mantissa adder/normaliser under valid/ready.

---
 rtl/preadder_seq.sv | 212 +++++++++++++++++++++
 tb/tb_preadder_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/preadder_seq.sv
// preadder_seq: multi-cycle FP32 add/sub pre-adder sequencer.
// Accepts one operand pair and unpacks both mantissas to 28 bits.
// It aligns the smaller-exponent mantissa SHIFT_STEP bits per cycle, keeping a sticky bit.
// It then orders the two mantissas by magnitude and resolves the result sign.
// Optional build macro PREADDER_SEQ_FTZ_EN flushes subnormal inputs to signed zero at accept.
module preadder_seq #(
  parameter int SHIFT_STEP = 1,
  parameter int MAX_SHIFT  = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sign,
  output logic [7:0]  exp,
  output logic [27:0] mantis_great,
  output logic [27:0] mantis_small,
  output logic        special,
  output logic        nan,
  output logic        busy
);

  localparam int CW = $clog2(MAX_SHIFT + SHIFT_STEP + 1);
  localparam logic [CW-1:0] STEP_C      = CW'(SHIFT_STEP);
  localparam logic [CW-1:0] MAX_SHIFT_C = CW'(MAX_SHIFT);
  localparam logic [7:0]    MAX_SHIFT_8 = 8'(MAX_SHIFT);

  typedef enum logic [1:0] {IDLE, ALIGN, CMP, DONE} state_t;

  state_t state_reg, state_next;

  // Operand unpack, index 0 = A, 1 = B (B carries the effective sign after sub).
  logic [31:0] op_w   [2];
  logic        sgn_w  [2];
  logic [7:0]  exp_w  [2];
  logic [7:0]  eff_w  [2];
  logic [22:0] frac_w [2];
  logic [27:0] mant_w [2];
  logic        nan_w  [2];
  logic        inf_w  [2];

  assign op_w[0] = op_a;
  assign op_w[1] = op_b;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
      assign sgn_w[gi] = op_w[gi][31] ^ ((gi == 1) && sub);
      assign exp_w[gi] = op_w[gi][30:23];
`ifdef PREADDER_SEQ_FTZ_EN
      assign frac_w[gi] = (exp_w[gi] == 8'd0) ? 23'd0 : op_w[gi][22:0];
`else
      assign frac_w[gi] = op_w[gi][22:0];
`endif
      // Subnormals and zero behave as exponent 1 with no hidden bit.
      assign eff_w[gi]  = (exp_w[gi] == 8'd0) ? 8'd1 : exp_w[gi];
      assign mant_w[gi] = {1'b0, (exp_w[gi] != 8'd0), frac_w[gi], 3'b000};
      assign nan_w[gi]  = (exp_w[gi] == 8'hFF) && (frac_w[gi] != 23'd0);
      assign inf_w[gi]  = (exp_w[gi] == 8'hFF) && (frac_w[gi] == 23'd0);
    end
  endgenerate

  logic          is_special;
  logic          nan_res;
  logic          sign_special;
  logic          a_ge;
  logic [7:0]    exp_diff;
  logic [CW-1:0] shift_cnt;

  assign is_special   = (exp_w[0] == 8'hFF) || (exp_w[1] == 8'hFF);
  assign nan_res      = nan_w[0] || nan_w[1] || (inf_w[0] && inf_w[1] && (sgn_w[0] != sgn_w[1]));
  assign sign_special = nan_res ? 1'b0 : (inf_w[0] ? sgn_w[0] : sgn_w[1]);
  // On an exponent tie A stays fixed and B goes through the shifter.
  assign a_ge         = (eff_w[0] >= eff_w[1]);
  assign exp_diff     = a_ge ? (eff_w[0] - eff_w[1]) : (eff_w[1] - eff_w[0]);
  assign shift_cnt    = (exp_diff >= MAX_SHIFT_8) ? MAX_SHIFT_C : exp_diff[CW-1:0];

  // Working registers.
  logic [27:0]   fix_reg;
  logic [27:0]   sh_reg;
  logic          sign_fix_reg;
  logic          sign_sh_reg;
  logic [CW-1:0] rem_reg;
  logic          cap_reg;
  logic          sign_reg;
  logic [7:0]    exp_reg;
  logic [27:0]   great_reg;
  logic [27:0]   small_reg;
  logic          special_reg;
  logic          nan_reg;

  // One sticky-preserving alignment step: every bit shifted out is ORed into bit 0.
  logic [CW-1:0] step_amt;
  logic [27:0]   lost_mask;
  logic [27:0]   sh_step;

  assign step_amt  = (rem_reg > STEP_C) ? STEP_C : rem_reg;
  assign lost_mask = (28'd1 << step_amt) - 28'd1;
  assign sh_step   = (sh_reg >> step_amt) | {27'd0, |(sh_reg & lost_mask)};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (in_valid) state_next = is_special ? DONE : ALIGN;
      ALIGN:   if (rem_reg == '0) state_next = CMP;
      CMP:     state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load at accept, shift in ALIGN, order and sign in CMP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fix_reg      <= '0;
      sh_reg       <= '0;
      sign_fix_reg <= 1'b0;
      sign_sh_reg  <= 1'b0;
      rem_reg      <= '0;
      cap_reg      <= 1'b0;
      sign_reg     <= 1'b0;
      exp_reg      <= '0;
      great_reg    <= '0;
      small_reg    <= '0;
      special_reg  <= 1'b0;
      nan_reg      <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (in_valid) begin
            if (is_special) begin
              special_reg <= 1'b1;
              nan_reg     <= nan_res;
              sign_reg    <= sign_special;
              exp_reg     <= 8'hFF;
              great_reg   <= '0;
              small_reg   <= '0;
            end else begin
              special_reg <= 1'b0;
              nan_reg     <= 1'b0;
              exp_reg     <= a_ge ? eff_w[0] : eff_w[1];
              rem_reg     <= shift_cnt;
              cap_reg     <= (exp_diff >= MAX_SHIFT_8);
              if (a_ge) begin
                fix_reg      <= mant_w[0];
                sign_fix_reg <= sgn_w[0];
                sh_reg       <= mant_w[1];
                sign_sh_reg  <= sgn_w[1];
              end else begin
                fix_reg      <= mant_w[1];
                sign_fix_reg <= sgn_w[1];
                sh_reg       <= mant_w[0];
                sign_sh_reg  <= sgn_w[0];
              end
            end
          end
        end
        ALIGN: begin
          if (rem_reg == '0) begin
            // A capped shift leaves only the sticky bit of the small operand.
            if (cap_reg) sh_reg <= {27'd0, |sh_reg};
          end else begin
            sh_reg  <= sh_step;
            rem_reg <= rem_reg - step_amt;
          end
        end
        CMP: begin
          if (fix_reg > sh_reg) begin
            great_reg <= fix_reg;
            small_reg <= sh_reg;
            sign_reg  <= sign_fix_reg;
          end else if (fix_reg < sh_reg) begin
            great_reg <= sh_reg;
            small_reg <= fix_reg;
            sign_reg  <= sign_sh_reg;
          end else begin
            // Equal magnitudes cancel to +0 unless both signs agree.
            great_reg <= fix_reg;
            small_reg <= sh_reg;
            sign_reg  <= sign_fix_reg & sign_sh_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready     = (state_reg == IDLE);
  assign busy         = (state_reg != IDLE);
  assign out_valid    = (state_reg == DONE);
  assign sign         = sign_reg;
  assign exp          = exp_reg;
  assign mantis_great = great_reg;
  assign mantis_small = small_reg;
  assign special      = special_reg;
  assign nan          = nan_reg;

endmodule

// File: tb/tb_preadder_seq.sv
// tb_preadder_seq: directed vectors with literal expectations plus a per-cycle
// comparison against an arithmetic model of the pre-adder.
module tb_preadder_seq;

  localparam int STEP = 1;
  localparam int MAXS = 27;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic        sign;
  logic [7:0]  exp;
  logic [27:0] mantis_great;
  logic [27:0] mantis_small;
  logic        special;
  logic        nan;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  preadder_seq #(.SHIFT_STEP(STEP), .MAX_SHIFT(MAXS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sign(sign), .exp(exp), .mantis_great(mantis_great), .mantis_small(mantis_small),
    .special(special), .nan(nan), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        sp;
    logic        nn;
    logic        sg;
    logic [7:0]  e;
    logic [27:0] g;
    logic [27:0] s;
    int          lat;
    int          acc;
  } res_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, req);
    end
  endtask

  // Real-number view of the pre-adder: unpack, align with sticky, order by magnitude.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    res_t   r;
    int     ea, eb, d;
    longint fa, fb, ma, mb, mf, ms;
    logic   sa, sb, sf, ss, na, nb, ia, ib;
    r.sp = 0; r.nn = 0; r.sg = 0; r.e = 0; r.g = 0; r.s = 0; r.lat = 0; r.acc = 0;
    sa = a[31];
    sb = b[31] ^ s;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = longint'(a[22:0]);
    fb = longint'(b[22:0]);
`ifdef PREADDER_SEQ_FTZ_EN
    if (ea == 0) fa = 0;
    if (eb == 0) fb = 0;
`endif
    na = (ea == 255) && (fa != 0);
    nb = (eb == 255) && (fb != 0);
    ia = (ea == 255) && (fa == 0);
    ib = (eb == 255) && (fb == 0);
    if (ea == 255 || eb == 255) begin
      r.sp = 1;
      r.e  = 8'hFF;
      r.nn = na || nb || (ia && ib && (sa != sb));
      r.sg = r.nn ? 1'b0 : (ia ? sa : sb);
      return r;
    end
    ma = ((ea != 0) ? longint'(67108864) : longint'(0)) + fa * 8;
    mb = ((eb != 0) ? longint'(67108864) : longint'(0)) + fb * 8;
    if (ea == 0) ea = 1;
    if (eb == 0) eb = 1;
    if (ea >= eb) begin
      mf = ma; sf = sa; ms = mb; ss = sb; d = ea - eb; r.e = 8'(ea);
    end else begin
      mf = mb; sf = sb; ms = ma; ss = sa; d = eb - ea; r.e = 8'(eb);
    end
    if (d >= MAXS) begin
      ms = (ms != 0) ? 1 : 0;
      d  = MAXS;
    end else begin
      ms = (ms >> d) | ((((ms & ((longint'(1) << d) - 1))) != 0) ? 1 : 0);
    end
    r.lat = 2 + (d + STEP - 1) / STEP;
    if (mf > ms) begin
      r.g = 28'(mf); r.s = 28'(ms); r.sg = sf;
    end else if (mf < ms) begin
      r.g = 28'(ms); r.s = 28'(mf); r.sg = ss;
    end else begin
      r.g = 28'(mf); r.s = 28'(ms); r.sg = (sf == ss) ? sf : 1'b0;
    end
    return r;
  endfunction

  // Compare process: every cycle, check the DUT against the model for the transaction in flight.
  res_t exp_q[$];
  bit   front_seen = 0;

  always @(negedge clk) begin
    res_t r;
    if (!rst_n) begin
      exp_q.delete();
      front_seen = 0;
    end else begin
      if (exp_q.size() != 0) begin
        chk("m_in_ready", in_ready, 0);
        if (out_valid) begin
          if (!front_seen) begin
            chk("m_latency", 64'(cyc - exp_q[0].acc - 1), 64'(exp_q[0].lat));
            front_seen = 1;
          end
          chk("m_special", special, exp_q[0].sp);
          chk("m_nan", nan, exp_q[0].nn);
          chk("m_sign", sign, exp_q[0].sg);
          chk("m_exp", exp, exp_q[0].e);
          chk("m_great", mantis_great, exp_q[0].g);
          chk("m_small", mantis_small, exp_q[0].s);
          if (out_ready) begin
            void'(exp_q.pop_front());
            front_seen = 0;
          end
        end
      end else begin
        chk("m_idle_valid", out_valid, 0);
        chk("m_idle_ready", in_ready, 1);
      end
      if (in_valid && in_ready) begin
        r = model(op_a, op_b, sub);
        r.acc = cyc;
        exp_q.push_back(r);
      end
    end
  end

  // One transaction with literal expectations; lat counts edges after the accept edge
  // (special operands reach DONE on the accept edge itself).
  task automatic run(input string nm, input logic [31:0] a, input logic [31:0] b, input logic s,
                     input int hold, input logic [7:0] ee, input logic [27:0] eg,
                     input logic [27:0] es, input logic esg, input logic esp, input logic enan,
                     input int elat);
    int n;
    @(posedge clk); #1;
    op_a = a; op_b = b; sub = s; in_valid = 1'b1; out_ready = (hold == 0);
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk({nm, "_accept_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk({nm, "_latency"}, 64'(n), 64'(elat));
    chk({nm, "_exp"}, exp, ee);
    chk({nm, "_great"}, mantis_great, eg);
    chk({nm, "_small"}, mantis_small, es);
    chk({nm, "_sign"}, sign, esg);
    chk({nm, "_special"}, special, esp);
    chk({nm, "_nan"}, nan, enan);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({nm, "_hold_valid"}, out_valid, 1);
      chk({nm, "_hold_ready"}, in_ready, 0);
      chk({nm, "_hold_great"}, mantis_great, eg);
      chk({nm, "_hold_small"}, mantis_small, es);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, "_after_valid"}, out_valid, 0);
    chk({nm, "_after_ready"}, in_ready, 1);
    out_ready = 1'b0;
    $display("txn %s: a=%08h b=%08h sub=%0d -> exp=%02h great=%07h small=%07h sign=%0d special=%0d nan=%0d lat=%0d",
             nm, a, b, s, exp, mantis_great, mantis_small, sign, special, nan, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    res_t pr;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0; sub = 1'b0;

    // Pin the model against hand-worked values.
    pr = model(32'h3F800000, 32'h3F000000, 1'b0);
    chk("pin_half_small", pr.s, 28'h2000000);
    chk("pin_half_lat", 64'(pr.lat), 3);
    pr = model(32'h40000000, 32'h40400000, 1'b1);
    chk("pin_sub_great", pr.g, 28'h6000000);
    chk("pin_sub_sign", pr.sg, 1);
    pr = model(32'h3F800000, 32'h3D800001, 1'b0);
    chk("pin_sticky_small", pr.s, 28'h0400001);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_exp", exp, 0);
    chk("rst_great", mantis_great, 0);
    chk("rst_small", mantis_small, 0);
    chk("rst_flags", {sign, special, nan}, 0);

    //   name        op_a          op_b          sub hold exp    great         small         sg sp nan lat
    run("one_one",   32'h3F800000, 32'h3F800000, 0,  0, 8'h7F, 28'h4000000, 28'h4000000, 0, 0, 0, 2);
    run("one_half",  32'h3F800000, 32'h3F000000, 0,  0, 8'h7F, 28'h4000000, 28'h2000000, 0, 0, 0, 3);
    run("cap_d30",   32'h3F800000, 32'h30800000, 0,  0, 8'h7F, 28'h4000000, 28'h0000001, 0, 0, 0, 29);
    run("two_m_3",   32'h40000000, 32'h40400000, 1,  0, 8'h80, 28'h6000000, 28'h4000000, 1, 0, 0, 2);
    run("one_m_one", 32'h3F800000, 32'h3F800000, 1,  0, 8'h7F, 28'h4000000, 28'h4000000, 0, 0, 0, 2);
    run("neg2_p1",   32'hC0000000, 32'h3F800000, 0,  0, 8'h80, 28'h4000000, 28'h2000000, 1, 0, 0, 3);
    run("sticky_d4", 32'h3F800000, 32'h3D800001, 0,  0, 8'h7F, 28'h4000000, 28'h0400001, 0, 0, 0, 6);
    run("inf_p1",    32'h7F800000, 32'h3F800000, 0,  0, 8'hFF, 28'h0,       28'h0,       0, 1, 0, 0);
    run("inf_m_inf", 32'h7F800000, 32'h7F800000, 1,  0, 8'hFF, 28'h0,       28'h0,       0, 1, 1, 0);
    run("p1_m_inf",  32'h3F800000, 32'h7F800000, 1,  0, 8'hFF, 28'h0,       28'h0,       1, 1, 0, 0);
    run("nan_p1",    32'h7FC00000, 32'h3F800000, 0,  0, 8'hFF, 28'h0,       28'h0,       0, 1, 1, 0);
    run("hold5",     32'h3F800000, 32'h3F000000, 0,  5, 8'h7F, 28'h4000000, 28'h2000000, 0, 0, 0, 3);
`ifdef PREADDER_SEQ_FTZ_EN
    run("subn_ftz",  32'h00000001, 32'h3F800000, 0,  0, 8'h7F, 28'h4000000, 28'h0000000, 0, 0, 0, 29);
`else
    run("subn",      32'h00000001, 32'h3F800000, 0,  0, 8'h7F, 28'h4000000, 28'h0000001, 0, 0, 0, 29);
`endif

    // Reset in the middle of a long alignment discards the operation at once.
    @(posedge clk); #1;
    op_a = 32'h3F800000; op_b = 32'h30800000; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_busy_before_edge", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    $display("txn midrst: reset asserted during ALIGN -> busy=%0d in_ready=%0d", busy, in_ready);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    run("post_rst",  32'h3F800000, 32'h3F000000, 0,  0, 8'h7F, 28'h4000000, 28'h2000000, 0, 0, 0, 3);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
